// File: rtl/carry_skip_adder_sync.sv
// Purpose : N-bit carry-skip adder (BLOCK_SIZE-bit ripple blocks) with registered sum/cout.
// Latency : 1 cycle, in_valid at edge T -> sum/cout/out_valid updated at edge T.
// Backpress: none; accepts one add every cycle, out_valid mirrors in_valid one cycle later.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid       qualifies a/b/cin for capture
//   a, b, cin      unsigned N-bit operands and carry-in
//   sum, cout      registered (a + b + cin); cout is bit N of the full sum
//   out_valid      one-cycle strobe marking a freshly loaded sum/cout
//
// Build option: CARRY_SKIP_ADDER_SKIP_EN
//   defined     -> each block carry-out is muxed between block carry-in and ripple carry
//   not defined -> plain N-bit ripple chain, no block propagate logic
module carry_skip_adder_sync #(
  parameter int N          = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         out_valid
);

  localparam int NB = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N-1:0] sum_core;
  logic         cout_core;

  assign p = a ^ b;
  assign g = a & b;

  // Carries are kept as per-bit / per-block scalars inside the generate scopes
  // so the chain is not one self-referencing vector.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLOCK_SIZE;
    localparam int HI = (LO + BLOCK_SIZE > N) ? N - 1 : LO + BLOCK_SIZE - 1;
    localparam int W  = HI - LO + 1;

    logic c_in;
    logic c_out;
    logic rip_c;

    if (k == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_chain
      assign c_in = g_blk[k-1].c_out;
    end

    for (genvar j = 0; j < W; j++) begin : g_bit
      logic ci;
      logic co;
      if (j == 0) begin : g_lsb
        assign ci = c_in;
      end else begin : g_rip
        assign ci = g_bit[j-1].co;
      end
      assign co             = g[LO+j] | (p[LO+j] & ci);
      assign sum_core[LO+j] = p[LO+j] ^ ci;
    end

    assign rip_c = g_bit[W-1].co;

`ifdef CARRY_SKIP_ADDER_SKIP_EN
    // When every bit propagates, the ripple carry equals c_in anyway; the mux
    // only shortens the path, never changes the value.
    logic blk_p;
    assign blk_p = &p[HI:LO];
    assign c_out = blk_p ? c_in : rip_c;
`else
    assign c_out = rip_c;
`endif
  end

  assign cout_core = g_blk[NB-1].c_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_core;
        cout <= cout_core;
      end
    end
  end

endmodule

// File: tb/tb_carry_skip_adder_sync.sv
module tb_carry_skip_adder_sync;

  localparam int NCFG = 7;
  localparam int NS  [NCFG] = '{1, 7, 8, 8, 16, 32, 16};
  localparam int BSS [NCFG] = '{2, 40, 4, 3, 5, 1, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin_s = 1'b0;
  logic [31:0] a_s = '0;
  logic [31:0] b_s = '0;

  int tests = 0;
  int fails = 0;

  event issue_ev;
  event chk_done;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int NN = NS[gi];

    logic [NN-1:0] sum;
    logic          cout;
    logic          out_valid;
    logic [NN:0]   exp_q[$];
    logic [NN:0]   last = '0;
    logic [NN:0]   exp_v;

    carry_skip_adder_sync #(.N(NN), .BLOCK_SIZE(BSS[gi])) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a_s[NN-1:0]),
      .b        (b_s[NN-1:0]),
      .cin      (cin_s),
      .sum      (sum),
      .cout     (cout),
      .out_valid(out_valid)
    );

    // Reference model: plain (NN+1)-bit integer addition.
    always @(issue_ev) begin
      if (in_valid && rst_n)
        exp_q.push_back({1'b0, a_s[NN-1:0]} + {1'b0, b_s[NN-1:0]} + {{NN{1'b0}}, cin_s});
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        tests++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
          fails++;
          $display("FAIL reset_clear cfg%0d: got valid=%0b cout=%0b sum=%0h, want 0 0 0",
                   gi, out_valid, cout, sum);
        end
        exp_q.delete();
        last = '0;
      end else if (out_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid cfg%0d: got out_valid=1 cout=%0b sum=%0h, want no result",
                   gi, cout, sum);
        end else begin
          exp_v = exp_q.pop_front();
          if ({cout, sum} !== exp_v) begin
            fails++;
            $display("FAIL add cfg%0d(N=%0d,BS=%0d): got cout=%0b sum=%0h, want cout=%0b sum=%0h",
                     gi, NN, BSS[gi], cout, sum, exp_v[NN], exp_v[NN-1:0]);
          end
          last = exp_v;
        end
      end else begin
        tests++;
        if (out_valid !== 1'b0 || {cout, sum} !== last) begin
          fails++;
          $display("FAIL hold cfg%0d: got valid=%0b cout=%0b sum=%0h, want valid=0 cout=%0b sum=%0h",
                   gi, out_valid, cout, sum, last[NN], last[NN-1:0]);
        end
      end
    end

    always @(chk_done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL drain cfg%0d: got %0d results outstanding, want 0", gi, exp_q.size());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                       input logic c);
    @(negedge clk);
    in_valid = v;
    a_s      = aa;
    b_s      = bb;
    cin_s    = c;
    -> issue_ev;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = '1;
      2:       r = 32'd1 << $urandom_range(0, 31);
      default: r = $urandom();
    endcase
    return r;
  endfunction

  task automatic reset_phase(input int cycles);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      a_s   = $urandom();
      b_s   = $urandom();
      cin_s = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1;
    // Power-on reset with valid inputs present: outputs must stay cleared.
    reset_phase(4);

    // Single-bit exhaustive (also drives the low bits of every wider config).
    for (int x = 0; x < 8; x++) begin
      logic [2:0] v3;
      v3 = 3'(x);
      drive(1'b1, {31'b0, v3[2]}, {31'b0, v3[1]}, v3[0]);
    end

    // Full propagate, partial-block vectors, carry into the top bit.
    drive(1'b1, 32'h0000_00FF, 32'h0000_0000, 1'b1);
    drive(1'b1, 32'h0000_00A5, 32'h0000_005B, 1'b0);
    drive(1'b1, 32'h0000_007F, 32'h0000_0001, 1'b0);
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drive(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);

    // Valid pattern 1,0,1,1 with distinct operands; the gap must hold sum.
    drive(1'b1, 32'h1111_2222, 32'h0303_0404, 1'b0);
    drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    drive(1'b1, 32'h0F0F_0F0F, 32'h7070_7070, 1'b1);
    drive(1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0);

    // Mid-stream reset: asserted between clock edges, checked before the next edge.
    drive(1'b1, 32'h0000_1234, 32'h0000_0001, 1'b0);
    drive(1'b1, 32'h5555_5555, 32'h2222_2222, 1'b1);
    reset_phase(2);

    // Randomised regression with random valid gaps.
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
    end

    repeat (3) drive(1'b0, $urandom(), $urandom(), 1'b0);
    @(negedge clk);
    -> chk_done;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carry_skip_adder_sync.md
# carry_skip_adder_sync

Parameterised N-bit carry-skip adder with registered outputs. It adds two N-bit operands and a carry-in, and presents the N-bit sum and the carry-out one clock after a valid input. The adder is split into ripple-carry blocks of BLOCK_SIZE bits, and each block has a propagate-based skip multiplexer. It is a datapath leaf used wherever a single-cycle registered add is needed.

## Interface
- `N`, default 16: operand and sum width in bits; must be ≥ 1.
- `BLOCK_SIZE`, default 4: bits per carry-skip block; must be ≥ 1; may exceed N.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  qualifies `a`, `b`, `cin` for capture.
- `a`  in  N  operand A, unsigned.
- `b`  in  N  operand B, unsigned.
- `cin`  in  1  carry-in.
- `sum`  out  N  registered `(a + b + cin) mod 2^N`.
- `cout`  out  1  registered carry-out, bit N of the full sum.
- `out_valid`  out  1  high for one cycle when `sum`/`cout` carry a new result.

## Operation
- The combinational core partitions bits into `ceil(N/BLOCK_SIZE)` blocks, ordered LSB first.
- The last block is partial when `N % BLOCK_SIZE != 0`.
- When `BLOCK_SIZE ≥ N` there is a single block.
- Within a block, carries ripple through full adders. Per bit:
  - `p_i = a_i ^ b_i`
  - `g_i = a_i & b_i`
  - `s_i = p_i ^ c_i`
  - `c_{i+1} = g_i | (p_i & c_i)`
- Block propagate `P_blk` is the AND of all `p_i` in the block.
- Block carry-out is `P_blk ? c_blk_in : ripple_cout`.
- Block 0 carry-in is `cin`. Block k carry-in is the carry-out of block k-1.
- `cout` is the carry-out of the final block.
- The result is arithmetically exact for all inputs. The skip path must never change the value, only the critical path.
- Output register on `clk` rising edge:
  - If `in_valid` is high: `sum`/`cout` load the core result and `out_valid` is set to 1.
  - If `in_valid` is low: `sum`/`cout` hold their previous value and `out_valid` is set to 0.
- Reset (`rst_n` low, asynchronous): `sum = 0`, `cout = 0`, `out_valid = 0` immediately, independent of `clk`. They are held until `rst_n` deasserts.
- There is no X-propagation masking: inputs are sampled only when `in_valid` is high.

## Timing
- Latency is 1 cycle: inputs valid at edge T give outputs at edge T, observable after T, with `out_valid` high for the cycle T→T+1.
- Throughput is one add per cycle. Back-to-back `in_valid` produces back-to-back `out_valid`.
- The core is purely combinational from `a`/`b`/`cin` to the register D inputs. Its worst-case path is:
  - ripple through block 0,
  - then the skip muxes across the middle blocks,
  - then ripple through the last block.
- Reset asserted mid-stream: outputs clear asynchronously. The first capture after deassertion is at the first rising edge with `rst_n` high and `in_valid` high.
- Wrap-around: an overflow yields `sum` modulo 2^N with `cout = 1`. No saturation is applied.

## Configuration
- Macro: `CARRY_SKIP_ADDER_SKIP_EN`.
- Defined: the block skip multiplexers are instantiated as described in Operation.
- Not defined: the carry chain is a plain N-bit ripple. Each block carry-out is the ripple carry and no `P_blk` logic is generated.
- Both builds must produce bit-identical `sum`/`cout` for every input. Only the timing structure differs.

## Test plan
- Reset: hold `rst_n = 0` with random inputs and `in_valid = 1` → `sum = 0`, `cout = 0`, `out_valid = 0`. Assert `rst_n` low mid-stream → outputs clear with no clock edge.
- N=1, BLOCK_SIZE=2, exhaustive 8 vectors with `in_valid = 1`, for example:
  - a=1, b=0, cin=0 → sum=1, cout=0
  - a=1, b=0, cin=1 → sum=0, cout=1
  - a=1, b=1, cin=1 → sum=1, cout=1
  - a=0, b=1, cin=1 → sum=0, cout=1
  - all results one cycle later.
- N=8, BLOCK_SIZE=4, full propagate: a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. This exercises both skip paths.
- N=8, BLOCK_SIZE=3 (partial block), a=0xA5, b=0x5B, cin=0 → sum=0x00, cout=1. Also a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0.
- Handshake: drive `in_valid` as 1,0,1,1 with distinct operands → `out_valid` reads 1,0,1,1 one cycle later, and `sum` holds its value during the gap cycle.
- Random regression for N ∈ {1, 7, 16, 32} and BLOCK_SIZE ∈ {1, 2, 4, 5, 40}, built with and without `CARRY_SKIP_ADDER_SKIP_EN` → `{cout, sum}` equals `a + b + cin` on every valid cycle.
